// File: rtl/slv_req_arbiter_pkg.sv
// slv_req_arbiter_pkg: state encoding, sizing constants and the register
// struct (with its reset value) for slv_req_arbiter.
// Configuration macro: SLV_REQ_ARB_RR_EN (defined = round-robin, adds the
// last-owner register; undefined = fixed priority to port 0).
package slv_req_arbiter_pkg;

  localparam int unsigned ARB_PORTS     = 2;
  localparam int unsigned ARB_CNT_BITS  = 4;
  localparam int unsigned ARB_SIZE_BITS = 8;

  localparam logic [ARB_CNT_BITS-1:0] ARB_OUTSTANDING_MAX = 4'd15;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_DRAIN = 2'd2
  } arb_state_e;

  typedef struct packed {
    arb_state_e              state;
    logic                    owner;
    logic [ARB_CNT_BITS-1:0] outstanding;
`ifdef SLV_REQ_ARB_RR_EN
    logic                    last_owner;
`endif
  } arb_reg_t;

  // last_owner resets to 1 so port 0 wins the first contested round.
  localparam arb_reg_t ARB_REG_RESET = '{
    state:       ARB_IDLE,
    owner:       1'b0,
`ifdef SLV_REQ_ARB_RR_EN
    outstanding: '0,
    last_owner:  1'b1
`else
    outstanding: '0
`endif
  };

endpackage

// File: rtl/types_amba_pkg.sv
// types_amba_pkg: system bus width constants shared by bus-facing blocks.
package types_amba_pkg;

  localparam int unsigned CFG_SYSBUS_ADDR_BITS  = 32;
  localparam int unsigned CFG_SYSBUS_DATA_BITS  = 64;
  localparam int unsigned CFG_SYSBUS_DATA_BYTES = CFG_SYSBUS_DATA_BITS / 8;

endpackage

// File: rtl/slv_req_arbiter.sv
// slv_req_arbiter: two-requester arbiter in front of one shared memory port.
// A grant is locked for a whole burst (until a beat with last is accepted),
// then the arbiter drains outstanding responses before re-arbitrating.
//
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_req_*  [1:0]          per-requester request (valid/addr/size/write/wdata/wstrb/last)
//   o_req_ready [1:0]       per-requester accept
//   o_resp_valid [1:0]      per-requester response valid; rdata/err shared
//   o_mem_req_*             request to the shared memory port, i_mem_req_ready accept
//   i_mem_resp_*            memory response (valid/rdata/err)
//   o_owner, o_busy         current grant owner, non-idle indicator
//
// Configuration macro: SLV_REQ_ARB_RR_EN selects round-robin arbitration;
// when undefined port 0 has fixed priority.
module slv_req_arbiter
  import types_amba_pkg::*;
  import slv_req_arbiter_pkg::*;
(
  input  logic                                             i_clk,
  input  logic                                             i_rst,
  input  logic [ARB_PORTS-1:0]                             i_req_valid,
  input  logic [ARB_PORTS-1:0][CFG_SYSBUS_ADDR_BITS-1:0]   i_req_addr,
  input  logic [ARB_PORTS-1:0][ARB_SIZE_BITS-1:0]          i_req_size,
  input  logic [ARB_PORTS-1:0]                             i_req_write,
  input  logic [ARB_PORTS-1:0][CFG_SYSBUS_DATA_BITS-1:0]   i_req_wdata,
  input  logic [ARB_PORTS-1:0][CFG_SYSBUS_DATA_BYTES-1:0]  i_req_wstrb,
  input  logic [ARB_PORTS-1:0]                             i_req_last,
  output logic [ARB_PORTS-1:0]                             o_req_ready,
  output logic [ARB_PORTS-1:0]                             o_resp_valid,
  output logic [CFG_SYSBUS_DATA_BITS-1:0]                  o_resp_rdata,
  output logic                                             o_resp_err,
  output logic                                             o_mem_req_valid,
  output logic [CFG_SYSBUS_ADDR_BITS-1:0]                  o_mem_req_addr,
  output logic [ARB_SIZE_BITS-1:0]                         o_mem_req_size,
  output logic                                             o_mem_req_write,
  output logic [CFG_SYSBUS_DATA_BITS-1:0]                  o_mem_req_wdata,
  output logic [CFG_SYSBUS_DATA_BYTES-1:0]                 o_mem_req_wstrb,
  output logic                                             o_mem_req_last,
  input  logic                                             i_mem_req_ready,
  input  logic                                             i_mem_resp_valid,
  input  logic [CFG_SYSBUS_DATA_BITS-1:0]                  i_mem_resp_rdata,
  input  logic                                             i_mem_resp_err,
  output logic                                             o_owner,
  output logic                                             o_busy
);

  arb_reg_t r;
  arb_reg_t v;
  logic     full;
  logic     own_ready;
  logic     accept;
  logic     dec;
  logic     sel;

  // Arbitration pick; only consulted when at least one port is valid.
`ifdef SLV_REQ_ARB_RR_EN
  function automatic logic arb_select(input logic [1:0] valid, input logic last_owner);
    if (valid == 2'b11) return ~last_owner;
    return (valid == 2'b10);
  endfunction
`else
  function automatic logic arb_select(input logic [1:0] valid);
    return (valid == 2'b10);
  endfunction
`endif

  // Next-state and output decode.
  always_comb begin
    v               = r;
    o_req_ready     = '0;
    o_resp_valid    = '0;
    o_mem_req_valid = 1'b0;

`ifdef SLV_REQ_ARB_RR_EN
    sel = arb_select(i_req_valid, r.last_owner);
`else
    sel = arb_select(i_req_valid);
`endif

    full      = (r.outstanding == ARB_OUTSTANDING_MAX);
    own_ready = (r.state == ARB_GRANT) & i_mem_req_ready & ~full;
    accept    = i_req_valid[r.owner] & own_ready;
    // A response with nothing outstanding is still forwarded but never decrements.
    dec       = i_mem_resp_valid & (r.outstanding != '0);
    v.outstanding = r.outstanding + ARB_CNT_BITS'(accept) - ARB_CNT_BITS'(dec);

    // Data fields always follow the current owner, valid is gated by state.
    o_mem_req_addr  = i_req_addr[r.owner];
    o_mem_req_size  = i_req_size[r.owner];
    o_mem_req_write = i_req_write[r.owner];
    o_mem_req_wdata = i_req_wdata[r.owner];
    o_mem_req_wstrb = i_req_wstrb[r.owner];
    o_mem_req_last  = i_req_last[r.owner];

    o_resp_valid[r.owner] = i_mem_resp_valid;
    o_resp_rdata          = i_mem_resp_rdata;
    o_resp_err            = i_mem_resp_err;

    case (r.state)
      ARB_IDLE: begin
        if (|i_req_valid) begin
          v.owner = sel;
          v.state = ARB_GRANT;
`ifdef SLV_REQ_ARB_RR_EN
          v.last_owner = sel;
`endif
        end
      end
      ARB_GRANT: begin
        o_mem_req_valid       = i_req_valid[r.owner] & ~full;
        o_req_ready[r.owner]  = own_ready;
        if (accept && i_req_last[r.owner]) v.state = ARB_DRAIN;
      end
      ARB_DRAIN: begin
        if (v.outstanding == '0) v.state = ARB_IDLE;
      end
      default: v.state = ARB_IDLE;
    endcase

    o_owner = r.owner;
    o_busy  = (r.state != ARB_IDLE);
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r <= ARB_REG_RESET;
    else       r <= v;
  end

endmodule

// File: tb/tb_slv_req_arbiter.sv
// tb_slv_req_arbiter: directed self-checking bench for slv_req_arbiter.
// Inputs change 1 ns after a rising edge; outputs are sampled on the falling edge.
// Expectations for the contested-burst scenario follow SLV_REQ_ARB_RR_EN.
module tb_slv_req_arbiter;
  import types_amba_pkg::*;

  logic                                       clk;
  logic                                       rst;
  logic [1:0]                                 req_valid;
  logic [1:0][CFG_SYSBUS_ADDR_BITS-1:0]       req_addr;
  logic [1:0][7:0]                            req_size;
  logic [1:0]                                 req_write;
  logic [1:0][CFG_SYSBUS_DATA_BITS-1:0]       req_wdata;
  logic [1:0][CFG_SYSBUS_DATA_BYTES-1:0]      req_wstrb;
  logic [1:0]                                 req_last;
  logic [1:0]                                 req_ready;
  logic [1:0]                                 resp_valid;
  logic [CFG_SYSBUS_DATA_BITS-1:0]            resp_rdata;
  logic                                       resp_err;
  logic                                       mem_req_valid;
  logic [CFG_SYSBUS_ADDR_BITS-1:0]            mem_req_addr;
  logic [7:0]                                 mem_req_size;
  logic                                       mem_req_write;
  logic [CFG_SYSBUS_DATA_BITS-1:0]            mem_req_wdata;
  logic [CFG_SYSBUS_DATA_BYTES-1:0]           mem_req_wstrb;
  logic                                       mem_req_last;
  logic                                       mem_req_ready;
  logic                                       mem_resp_valid;
  logic [CFG_SYSBUS_DATA_BITS-1:0]            mem_resp_rdata;
  logic                                       mem_resp_err;
  logic                                       owner;
  logic                                       busy;

  int n_assert = 0;
  int n_fail   = 0;

  slv_req_arbiter dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_req_valid      (req_valid),
    .i_req_addr       (req_addr),
    .i_req_size       (req_size),
    .i_req_write      (req_write),
    .i_req_wdata      (req_wdata),
    .i_req_wstrb      (req_wstrb),
    .i_req_last       (req_last),
    .o_req_ready      (req_ready),
    .o_resp_valid     (resp_valid),
    .o_resp_rdata     (resp_rdata),
    .o_resp_err       (resp_err),
    .o_mem_req_valid  (mem_req_valid),
    .o_mem_req_addr   (mem_req_addr),
    .o_mem_req_size   (mem_req_size),
    .o_mem_req_write  (mem_req_write),
    .o_mem_req_wdata  (mem_req_wdata),
    .o_mem_req_wstrb  (mem_req_wstrb),
    .o_mem_req_last   (mem_req_last),
    .i_mem_req_ready  (mem_req_ready),
    .i_mem_resp_valid (mem_resp_valid),
    .i_mem_resp_rdata (mem_resp_rdata),
    .i_mem_resp_err   (mem_resp_err),
    .o_owner          (owner),
    .o_busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge (input drive point).
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Move to the falling edge (sample point).
  task automatic look();
    #4;
  endtask

  initial begin
    logic eo;

    rst            = 1'b1;
    req_valid      = '0;
    req_addr       = '0;
    req_size       = '0;
    req_write      = '0;
    req_wdata[0]   = 64'hA5A5_0000_A5A5_0000;
    req_wdata[1]   = 64'h5A5A_1111_5A5A_1111;
    req_wstrb      = '0;
    req_last       = '0;
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;
    mem_resp_err   = 1'b0;

    // Reset values.
    nxt(); nxt(); look();
    chk("rst_ready", 64'(req_ready), 64'h0);
    chk("rst_resp_valid", 64'(resp_valid), 64'h0);
    chk("rst_mem_valid", 64'(mem_req_valid), 64'h0);
    chk("rst_owner", 64'(owner), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_wdata_from_port0", mem_req_wdata, 64'hA5A5_0000_A5A5_0000);

    // Port 0 single read at 0x100.
    nxt(); rst = 1'b0; req_valid = 2'b01; req_addr[0] = 32'h100; req_last = 2'b01; look();
    chk("t1_idle_mem_valid", 64'(mem_req_valid), 64'h0);
    chk("t1_idle_ready", 64'(req_ready), 64'h0);
    nxt(); look();
    chk("t1_grant_busy", 64'(busy), 64'h1);
    chk("t1_grant_mem_valid", 64'(mem_req_valid), 64'h1);
    chk("t1_grant_addr", 64'(mem_req_addr), 64'h100);
    chk("t1_grant_ready", 64'(req_ready), 64'h1);
    chk("t1_grant_owner", 64'(owner), 64'h0);
    nxt(); req_valid = '0; req_last = '0; mem_resp_valid = 1'b1;
    mem_resp_rdata = 64'h1234_5678_9ABC_DEF0; look();
    chk("t1_drain_busy", 64'(busy), 64'h1);
    chk("t1_drain_ready", 64'(req_ready), 64'h0);
    chk("t1_drain_mem_valid", 64'(mem_req_valid), 64'h0);
    chk("t1_resp_valid", 64'(resp_valid), 64'h1);
    chk("t1_resp_rdata", resp_rdata, 64'h1234_5678_9ABC_DEF0);
    nxt(); mem_resp_valid = 1'b0; look();
    chk("t1_idle_busy", 64'(busy), 64'h0);
    chk("t1_resp_off", 64'(resp_valid), 64'h0);

    // Both ports valid every cycle, 4-beat bursts, one response per cycle.
    req_addr[0] = 32'h1000; req_addr[1] = 32'h2000;
    for (int b = 0; b < 4; b++) begin
      nxt(); req_valid = 2'b11; req_last = '0; mem_resp_valid = 1'b1; look();
      chk("t2_idle_busy", 64'(busy), 64'h0);
`ifdef SLV_REQ_ARB_RR_EN
      // Port 0 won the previous round, so port 1 goes first here.
      eo = (b % 2 == 0);
`else
      eo = 1'b0;
`endif
      for (int beat = 0; beat < 4; beat++) begin
        nxt(); req_last = '0; req_last[eo] = (beat == 3); look();
        chk("t2_owner", 64'(owner), 64'(eo));
        chk("t2_mem_valid", 64'(mem_req_valid), 64'h1);
        chk("t2_addr", 64'(mem_req_addr), eo ? 64'h2000 : 64'h1000);
        chk("t2_ready", 64'(req_ready), eo ? 64'h2 : 64'h1);
      end
      nxt(); req_last = '0; look();
      chk("t2_drain_busy", 64'(busy), 64'h1);
      chk("t2_drain_ready", 64'(req_ready), 64'h0);
    end
    nxt(); req_valid = '0; mem_resp_valid = 1'b0; look();
    chk("t2_end_busy", 64'(busy), 64'h0);

    // 16-beat burst with responses withheld: 15 accepted, then stall.
    nxt(); req_valid = 2'b01; req_last = '0; look();
    chk("t3_idle_busy", 64'(busy), 64'h0);
    for (int beat = 0; beat < 15; beat++) begin
      nxt(); look();
      chk("t3_ready", 64'(req_ready), 64'h1);
      chk("t3_mem_valid", 64'(mem_req_valid), 64'h1);
    end
    for (int s = 0; s < 4; s++) begin
      nxt(); req_last = 2'b01; look();
      chk("t3_full_ready", 64'(req_ready), 64'h0);
      chk("t3_full_mem_valid", 64'(mem_req_valid), 64'h0);
      chk("t3_full_busy", 64'(busy), 64'h1);
    end
    nxt(); mem_resp_valid = 1'b1; look();
    chk("t3_resp_full_ready", 64'(req_ready), 64'h0);
    chk("t3_resp_valid", 64'(resp_valid), 64'h1);
    nxt(); mem_resp_valid = 1'b0; look();
    chk("t3_last_ready", 64'(req_ready), 64'h1);
    chk("t3_last_mem_valid", 64'(mem_req_valid), 64'h1);
    nxt(); req_valid = '0; req_last = '0; mem_resp_valid = 1'b1;
    for (int k = 0; k < 15; k++) begin
      look();
      chk("t3_drain_busy", 64'(busy), 64'h1);
      chk("t3_drain_ready", 64'(req_ready), 64'h0);
      nxt();
    end
    mem_resp_valid = 1'b0; look();
    chk("t3_done_busy", 64'(busy), 64'h0);

    // Port 1 burst: valid dropped mid-burst, accept+response with 2 outstanding.
    nxt(); req_valid = 2'b10; req_last = '0; look();
    chk("t4_idle_busy", 64'(busy), 64'h0);
    nxt(); look();
    chk("t4_owner", 64'(owner), 64'h1);
    chk("t4_ready", 64'(req_ready), 64'h2);
    nxt(); look();
    chk("t4_mem_valid", 64'(mem_req_valid), 64'h1);
    nxt(); req_valid = 2'b01; look();
    chk("t4_drop_owner", 64'(owner), 64'h1);
    chk("t4_drop_mem_valid", 64'(mem_req_valid), 64'h0);
    chk("t4_drop_ready", 64'(req_ready), 64'h2);
    chk("t4_drop_busy", 64'(busy), 64'h1);
    nxt(); req_valid = 2'b11; mem_resp_valid = 1'b1; look();
    chk("t4_both_ready", 64'(req_ready), 64'h2);
    chk("t4_both_resp_valid", 64'(resp_valid), 64'h2);
    chk("t4_both_addr", 64'(mem_req_addr), 64'h2000);
    nxt(); mem_resp_valid = 1'b0; req_last = 2'b10; look();
    chk("t4_last_ready", 64'(req_ready), 64'h2);
    chk("t4_last_mem_valid", 64'(mem_req_valid), 64'h1);
    nxt(); req_valid = '0; req_last = '0; mem_resp_valid = 1'b1; look();
    chk("t4_drain3_busy", 64'(busy), 64'h1);
    nxt(); look();
    chk("t4_drain2_busy", 64'(busy), 64'h1);
    nxt(); look();
    chk("t4_drain1_busy", 64'(busy), 64'h1);
    nxt(); mem_resp_valid = 1'b0; look();
    chk("t4_done_busy", 64'(busy), 64'h0);

    // Reset mid-burst with 3 outstanding on port 1.
    nxt(); req_valid = 2'b10; look();
    nxt(); look();
    chk("t5_owner_pre", 64'(owner), 64'h1);
    nxt(); look();
    nxt(); look();
    nxt(); rst = 1'b1; look();
    nxt(); rst = 1'b0; req_valid = '0; look();
    chk("t5_rst_ready", 64'(req_ready), 64'h0);
    chk("t5_rst_mem_valid", 64'(mem_req_valid), 64'h0);
    chk("t5_rst_owner", 64'(owner), 64'h0);
    chk("t5_rst_busy", 64'(busy), 64'h0);
    chk("t5_rst_resp_valid", 64'(resp_valid), 64'h0);
    nxt(); mem_resp_valid = 1'b1; look();
    chk("t5_late_resp", 64'(resp_valid), 64'h1);
    chk("t5_late_busy", 64'(busy), 64'h0);
    nxt(); mem_resp_valid = 1'b0; req_valid = 2'b11; req_last = 2'b11; look();
    chk("t5_idle_busy", 64'(busy), 64'h0);
    nxt(); look();
    chk("t5_owner", 64'(owner), 64'h0);
    chk("t5_ready", 64'(req_ready), 64'h1);
    nxt(); req_valid = '0; req_last = '0; mem_resp_valid = 1'b1; look();
    chk("t5_drain_busy", 64'(busy), 64'h1);
    nxt(); mem_resp_valid = 1'b0; look();
    chk("t5_done_busy", 64'(busy), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
